// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, frame lengths and idle line level.
// The PARITY state encoding exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int FRAME_8N1 = 10;
  localparam int FRAME_8E1 = 11;

  localparam logic LINE_IDLE = 1'b1;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// UART frame serializer: START/DATA/(PARITY)/STOP stepping on baud ticks, registered tx.
// PARITY stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_shift
  import uart_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       tx,
  output logic       busy
);

`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

  logic [2:0] state_r;
  logic [2:0] cnt_r;
  logic [7:0] data_r;
  logic       tx_r;

  // Frame sequencing; a tick in the load cycle is ignored because the load happens in IDLE.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      data_r  <= 8'h00;
      tx_r    <= LINE_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            data_r  <= load_data;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            tx_r    <= 1'b0;
            cnt_r   <= 3'd0;
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            tx_r  <= data_r[cnt_r];
            // counter only advances here, so 7->0 wrap coincides with leaving DATA
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              state_r <= AFTER_DATA;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            tx_r    <= even_parity(data_r);
            state_r <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            tx_r    <= LINE_IDLE;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = (state_r != ST_IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte sources.
// Optional even-parity frames (8E1) when UART_TX_PARITY_EN is defined; ports identical either way.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [ID_W-1:0]      gnt_id
);

  localparam int IDX_W = ID_W + 1;

  logic [ID_W-1:0]      last_gnt_r;
  logic [ID_W-1:0]      gnt_id_r;
  logic [ID_W-1:0]      start_s;
  logic [ID_W-1:0]      off_s;
  logic [ID_W-1:0]      sel_id_s;
  logic [IDX_W-1:0]     sum_s;
  logic [2*NUM_REQ-1:0] rot_s;
  logic                 probe_s;
  logic                 sel_valid_s;
  logic                 xfer_s;
  logic [7:0]           load_byte_s;

  // Round-robin pick: rotate valids so bit 0 is (last_gnt+1), take the lowest set bit.
  always_comb begin
    start_s     = (last_gnt_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : last_gnt_r + 1'b1;
    rot_s       = {req_valid, req_valid} >> start_s;
    sel_valid_s = 1'b0;
    off_s       = {ID_W{1'b0}};
    probe_s     = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      probe_s = 1'(rot_s >> j);
      if (probe_s) begin
        sel_valid_s = 1'b1;
        off_s       = ID_W'(j);
      end else begin
        off_s       = off_s;
      end
    end
    sum_s = {1'b0, start_s} + {1'b0, off_s};
    if (sum_s >= IDX_W'(NUM_REQ)) begin
      sel_id_s = ID_W'(sum_s - IDX_W'(NUM_REQ));
    end else begin
      sel_id_s = ID_W'(sum_s);
    end
  end

  assign xfer_s      = sel_valid_s & ~busy;
  assign req_ready   = xfer_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id_s) : {NUM_REQ{1'b0}};
  assign load_byte_s = 8'(req_data >> {sel_id_s, 3'b000});

  // Grant bookkeeping: requester 0 wins first after reset because last_gnt starts at NUM_REQ-1.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r <= ID_W'(NUM_REQ - 1);
      gnt_id_r   <= {ID_W{1'b0}};
    end else if (xfer_s) begin
      last_gnt_r <= sel_id_s;
      gnt_id_r   <= sel_id_s;
    end
  end

  assign gnt_id = gnt_id_r;

  uart_tx_shift u_shift (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .load      (xfer_s),
    .load_data (load_byte_s),
    .tx        (tx),
    .busy      (busy)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based line model. Honours UART_TX_PARITY_EN.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = FRAME_8E1;
`else
  localparam int FRAME = FRAME_8N1;
`endif

  logic           sys_clk = 1'b0;
  logic           rst_n;
  logic           baud_tick;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic           busy;
  logic [1:0]     gnt_id;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .gnt_id    (gnt_id)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] data;
    logic [3:0] exp_ready;
    int         exp_gnt;
    logic       exp_par;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      failures++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    baud_tick = 1'b0;
    req_valid = '0;
    req_data = '0;
    step();
    step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  // Expected line level for bit slot idx of a frame: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic par, input int idx);
    logic [7:0] t;
    if (idx == 0) return 1'b0;
    if (idx <= 8) begin
      t = d >> (idx - 1);
      return t[0];
    end
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return par;
`endif
    return 1'b1;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int   busy_cycles, nbits, ready_extra, early_start, nt, quiet_bad, r1_seen, got, ngrant, ngap, gap;
    logic abits[12];
    int   grants[5];
    logic measuring, prev_busy;
    logic [3:0] got_ready;
    int   m_last, m_gnt, sel;
    logic m_busy, m_tx;
    logic [7:0] d;
    logic [3:0] exp_ready;
    bit   q[$];

    tbl[0] = '{4'b0100, 8'h55, 4'b0100, 2, 1'b0};
    tbl[1] = '{4'b1111, 8'h07, 4'b1000, 3, 1'b1};
    tbl[2] = '{4'b0011, 8'h03, 4'b0001, 0, 1'b0};
    tbl[3] = '{4'b0011, 8'hA6, 4'b0010, 1, 1'b0};
    tbl[4] = '{4'b0000, 8'h00, 4'b0000, 1, 1'b0};
    tbl[5] = '{4'b1001, 8'hFF, 4'b1000, 3, 1'b0};
    tbl[6] = '{4'b0110, 8'h80, 4'b0010, 1, 1'b1};
    tbl[7] = '{4'b0001, 8'h3C, 4'b0001, 0, 1'b0};
    tbl[8] = '{4'b1110, 8'h01, 4'b0010, 1, 1'b1};
    tbl[9] = '{4'b1100, 8'hE0, 4'b0100, 2, 1'b1};

    // Vector table: arbitration order plus full frames with baud_tick held high.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      req_valid = tbl[r].valid;
      for (int i = 0; i < N; i++) req_data[i*8 +: 8] = (i == tbl[r].exp_gnt) ? tbl[r].data : ~tbl[r].data;
      baud_tick = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(tbl[r].exp_ready));
      step();
      req_valid = '0;
      chk($sformatf("vec%0d_gnt", r), 32'(gnt_id), 32'(tbl[r].exp_gnt));
      chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].exp_ready != 4'b0000));
      if (tbl[r].exp_ready != 4'b0000) begin
        chk($sformatf("vec%0d_tx_accept", r), 32'(tx), 32'd1);
        for (int b = 0; b < FRAME; b++) begin
          step();
          chk($sformatf("vec%0d_bit%0d", r, b), 32'(tx), 32'(frame_bit(tbl[r].data, tbl[r].exp_par, b)));
          chk($sformatf("vec%0d_busy%0d", r, b), 32'(busy), 32'(b != FRAME - 1));
        end
      end
      baud_tick = 1'b0;
      step();
    end

    // Single request 0x55 from requester 2, tick every 4 cycles, tick coincident with acceptance.
    do_reset();
    req_valid = 4'b0100;
    req_data = {8'h00, 8'h55, 8'h00, 8'h00};
    baud_tick = 1'b1;
    #1;
    chk("a_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("a_gnt", 32'(gnt_id), 32'd2);
    chk("a_tx_coincident", 32'(tx), 32'd1);
    busy_cycles = busy ? 1 : 0;
    nbits = 0;
    ready_extra = 0;
    early_start = 0;
    for (int c = 1; c < 100 && busy; c++) begin
      baud_tick = (c % 4 == 0);
      #1;
      if (req_ready != 4'b0000) ready_extra++;
      step();
      if (baud_tick) begin
        if (nbits < 12) abits[nbits] = tx;
        nbits++;
      end else if (nbits == 0 && tx != 1'b1) begin
        early_start++;
      end
      if (busy) busy_cycles++;
    end
    baud_tick = 1'b0;
    chk("a_nbits", 32'(nbits), 32'(FRAME));
    for (int b = 0; b < FRAME; b++) chk($sformatf("a_bit%0d", b), 32'(abits[b]), 32'(frame_bit(8'h55, 1'b0, b)));
    chk("a_busy_cycles", 32'(busy_cycles), 32'(4 * FRAME));
    chk("a_ready_once", 32'(ready_extra), 32'd0);
    chk("a_early_start", 32'(early_start), 32'd0);

    // All four valid continuously: grants 0,1,2,3,0 with a full stop period between frames.
    do_reset();
    req_valid = 4'b1111;
    req_data = 32'hC3A55A0F;
    ngrant = 0;
    ngap = 0;
    gap = 0;
    measuring = 1'b0;
    prev_busy = 1'b0;
    for (int c = 0; c < 600 && !(ngrant >= 5 && ngap >= 4); c++) begin
      baud_tick = (c % 4 == 0);
      #1;
      if (req_ready != 4'b0000) begin
        chk("b_onehot", 32'($countones(req_ready)), 32'd1);
        if (ngrant < 5) grants[ngrant] = onehot_idx(req_ready);
        ngrant++;
      end
      step();
      if (measuring) gap++;
      if (prev_busy && !busy) begin
        chk("b_stop_level", 32'(tx), 32'd1);
        measuring = 1'b1;
        gap = 0;
      end else if (measuring && !tx) begin
        chk_ge($sformatf("b_stop_gap%0d", ngap), gap, 4);
        measuring = 1'b0;
        ngap++;
      end
      prev_busy = busy;
    end
    req_valid = '0;
    baud_tick = 1'b0;
    chk("b_ngrant", 32'(ngrant), 32'd5);
    chk("b_ngap", 32'(ngap), 32'd4);
    for (int k = 0; k < 5; k++) chk($sformatf("b_grant%0d", k), 32'(grants[k]), 32'(k % 4));

    // Reset pulsed during data bit 4, then a clean frame from requester 0.
    do_reset();
    req_valid = 4'b0100;
    req_data = {8'h00, 8'hEF, 8'h00, 8'h00};
    baud_tick = 1'b1;
    #1;
    step();
    req_valid = '0;
    nt = 0;
    for (int c = 1; c < 100 && nt < 6; c++) begin
      baud_tick = (c % 4 == 0);
      #1;
      step();
      if (baud_tick) nt++;
    end
    baud_tick = 1'b0;
    chk("c_bit4_level", 32'(tx), 32'd0);
    chk("c_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c_rst_tx", 32'(tx), 32'd1);
    chk("c_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int c = 0; c < 12; c++) begin
      baud_tick = (c % 4 == 0);
      #1;
      step();
      if (tx != 1'b1 || busy != 1'b0) quiet_bad++;
    end
    chk("c_no_resume", 32'(quiet_bad), 32'd0);
    req_valid = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h96};
    baud_tick = 1'b1;
    #1;
    chk("c_ready_after", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("c_gnt_after", 32'(gnt_id), 32'd0);
    for (int b = 0; b < FRAME; b++) begin
      step();
      chk($sformatf("c_bit%0d", b), 32'(tx), 32'(frame_bit(8'h96, 1'b0, b)));
    end
    baud_tick = 1'b0;

    // Requester 1 drops valid before it can be granted; requester 3 must win.
    do_reset();
    req_valid = 4'b0001;
    req_data = 32'h0;
    baud_tick = 1'b1;
    #1;
    chk("e_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b1010;
    r1_seen = 0;
    got = -1;
    got_ready = 4'b0000;
    for (int c = 0; c < 60 && got < 0; c++) begin
      if (c == 5) req_valid = 4'b1000;
      #1;
      if (req_ready[1]) r1_seen++;
      if (req_ready != 4'b0000) begin
        got = onehot_idx(req_ready);
        got_ready = req_ready;
      end
      step();
    end
    req_valid = '0;
    chk("e_ready3", 32'(got_ready), 32'h8);
    chk("e_gnt3", 32'(gnt_id), 32'd3);
    chk("e_r1_never", 32'(r1_seen), 32'd0);
    for (int c = 0; c < 40 && busy; c++) step();
    baud_tick = 1'b0;

    // Randomized traffic against a transaction-level line model.
    do_reset();
    m_last = N - 1;
    m_gnt = 0;
    m_busy = 1'b0;
    m_tx = 1'b1;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req_data = $urandom();
      baud_tick = (c % 60 < 12) ? 1'b1 : ($urandom_range(0, 2) == 0);
      #1;
      sel = m_busy ? -1 : rr_pick(req_valid, m_last);
      exp_ready = (sel >= 0) ? 4'(1 << sel) : 4'b0000;
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (sel >= 0) begin
        m_last = sel;
        m_gnt = sel;
        d = req_data[sel*8 +: 8];
        q.delete();
        q.push_back(1'b0);
        for (int b = 0; b < 8; b++) q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
        q.push_back(^d);
`endif
        q.push_back(1'b1);
        m_busy = 1'b1;
      end else if (m_busy && baud_tick) begin
        m_tx = q.pop_front();
        if (q.size() == 0) m_busy = 1'b0;
      end
      step();
      chk("rnd_tx", 32'(tx), 32'(m_tx));
      chk("rnd_busy", 32'(busy), 32'(m_busy));
      chk("rnd_gnt", 32'(gnt_id), 32'(m_gnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
